// File: rtl/picorv32_arb_pkg.sv
// Shared types and constants for the two-requester PicoRV32 memory arbiter.
package picorv32_arb_pkg;

    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

    typedef struct packed {
        logic                  instr;
        logic [ARB_DATA_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [3:0]            wstrb;
    } mem_req_t;

endpackage

// File: rtl/picorv32_arb_rr_pick.sv
// Round-robin pick between two requesters; the one not served last wins a tie.
// Purely combinational, no latency; no backpressure of its own.
module picorv32_arb_rr_pick
    import picorv32_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = REQ0;
        case (valid)
            2'b01:   grant_id = REQ0;
            2'b10:   grant_id = REQ1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = REQ0;
        endcase
        grant = 2'b00;
        if (|valid) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one registered PicoRV32 memory port between two requesters, round-robin per transaction.
// Grant registers on the sampling edge; ready pulses the edge after mem_ready; min 3 cycles/transfer.
// Losing requester is held off by its ready staying low; downstream stalls by holding mem_ready low.
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_mem_valid,
    input  logic              m0_mem_instr,
    input  logic [DATA_W-1:0] m0_mem_addr,
    input  logic [DATA_W-1:0] m0_mem_wdata,
    input  logic [3:0]        m0_mem_wstrb,
    output logic              m0_mem_ready,
    output logic [DATA_W-1:0] m0_mem_rdata,

    input  logic              m1_mem_valid,
    input  logic              m1_mem_instr,
    input  logic [DATA_W-1:0] m1_mem_addr,
    input  logic [DATA_W-1:0] m1_mem_wdata,
    input  logic [3:0]        m1_mem_wstrb,
    output logic              m1_mem_ready,
    output logic [DATA_W-1:0] m1_mem_rdata,

    output logic              mem_valid,
    output logic              mem_instr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              grant_id,
    output logic              busy
);

    arb_state_t        state_q;
    arb_state_t        state_d;

    mem_req_t          req0;
    mem_req_t          req1;
    mem_req_t          req_sel;
    mem_req_t          req_q;

    logic [1:0]        req_valid;
    logic [1:0]        pick_grant;
    logic              pick_id;

    logic              take_grant;
    logic              finish;

    logic              mem_valid_q;
    logic              grant_id_q;
    logic              last_grant_q;
    logic              ready0_q;
    logic              ready1_q;
    logic [DATA_W-1:0] rdata_q;

    assign req0 = '{instr: m0_mem_instr, addr: m0_mem_addr, wdata: m0_mem_wdata, wstrb: m0_mem_wstrb};
    assign req1 = '{instr: m1_mem_instr, addr: m1_mem_addr, wdata: m1_mem_wdata, wstrb: m1_mem_wstrb};
    assign req_valid = {m1_mem_valid, m0_mem_valid};

    picorv32_arb_rr_pick u_pick (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_id   (pick_id)
    );

    always_comb begin
        case (pick_grant)
            2'b10:   req_sel = req1;
            default: req_sel = req0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE never grants: the finishing requester may still show valid for this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req_valid) state_d = ST_BUSY;
            ST_BUSY: if (mem_ready)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        take_grant = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: take_grant = |req_valid;
            ST_BUSY: begin
                finish = mem_ready;
                busy   = 1'b1;
            end
            ST_DONE: busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q        <= '{instr: 1'b0, addr: '0, wdata: '0, wstrb: WSTRB_READ};
            mem_valid_q  <= 1'b0;
            grant_id_q   <= REQ0;
            last_grant_q <= REQ1;
            rdata_q      <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
        end else begin
            ready0_q <= finish && (grant_id_q == REQ0);
            ready1_q <= finish && (grant_id_q == REQ1);
            if (take_grant) begin
                req_q        <= req_sel;
                mem_valid_q  <= 1'b1;
                grant_id_q   <= pick_id;
                last_grant_q <= pick_id;
            end
            if (finish) begin
                mem_valid_q <= 1'b0;
                rdata_q     <= mem_rdata;
            end
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_instr    = req_q.instr;
    assign mem_addr     = req_q.addr;
    assign mem_wdata    = req_q.wdata;
    assign mem_wstrb    = req_q.wstrb;
    assign grant_id     = grant_id_q;
    assign m0_mem_ready = ready0_q;
    assign m1_mem_ready = ready1_q;
    assign m0_mem_rdata = rdata_q;
    assign m1_mem_rdata = rdata_q;

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-requester arbiter sharing one PicoRV32 native memory port, which feeds picorv32_freeahb_adapter and the FreeAHB ahb_master, between two PicoRV32-style requesters (typically two cores, or an instruction port and a data port). It grants requesters round-robin and holds each grant for exactly one complete valid/ready transaction. It registers the forwarded request and the returned read data, so the shared downstream port only ever sees stable, handshake-correct traffic.

## Interface
- DATA_W, 32, data and address width; fixed at 32 for PicoRV32.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- m0_mem_valid / m1_mem_valid  in  1  requester n holds a request until its ready.
- m0_mem_instr / m1_mem_instr  in  1  request is an instruction fetch.
- m0_mem_addr / m1_mem_addr  in  32  byte address.
- m0_mem_wdata / m1_mem_wdata  in  32  write data.
- m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0000 means read.
- m0_mem_ready / m1_mem_ready  out  1  one-cycle completion pulse to requester n.
- m0_mem_rdata / m1_mem_rdata  out  32  read data, valid while the matching ready is high.
- mem_valid  out  1  downstream request, to the adapter.
- mem_instr, mem_addr, mem_wdata, mem_wstrb  out  1/32/32/4  registered copy of the granted request.
- mem_ready  in  1  downstream completion.
- mem_rdata  in  32  downstream read data, sampled when mem_ready is high.
- grant_id  out  1  requester currently or last served.
- busy  out  1  high in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No mN_mem_valid high: stay in IDLE.
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - On a grant: latch instr/addr/wdata/wstrb into the mem_* registers, set mem_valid=1, set grant_id and last_grant, then go to BUSY.
- BUSY:
  - mem_valid stays high and the mem_* fields stay stable until mem_ready is sampled high.
  - On mem_ready: mem_valid<=0, rdata register<=mem_rdata, granted mN_mem_ready<=1, go to DONE.
- DONE: the ready pulse is visible for this one cycle; clear it and go to IDLE. No new grant is taken in DONE, because the finishing requester's valid may still be sampled high here.
- The non-granted requester's ready stays 0 throughout. Its request is held off by ready staying low, never dropped.
- Both mN_mem_rdata ports are driven from the single rdata register. Only the matching ready qualifies the data.
- Writes follow the same sequence; rdata is don't-care for writes.
- Requester inputs are only sampled in IDLE. Changes while not granted are legal; changes while granted violate the PicoRV32 protocol and are ignored.

## Timing
- Reset values: state=IDLE, last_grant=1 (so m0 wins the first conflict), grant_id=0, busy=0, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, both mN_mem_ready=0, rdata=0.
- Latency:
  - Valid sampled at edge E0: mem_valid is high from E0.
  - mem_ready sampled at edge E1: mN_mem_ready is high for one cycle from E1, then IDLE.
  - Minimum 3 cycles per transaction with a zero-wait downstream.
- Back-to-back conflicts alternate strictly: 0,1,0,1...
- A single active requester is re-granted every third cycle; fairness costs nothing when the other requester is idle.
- mem_ready while not in BUSY is a downstream protocol error and is ignored.
- Reset mid-transaction: everything returns to reset values on the next edge and the in-flight request is abandoned. The adapter and ahb_master share this reset.

## Structure
- Package picorv32_arb_pkg holds the FSM state enum, the requester-id constants REQ0/REQ1, and the WSTRB_READ=4'b0000 constant.
- One sub-module is natural: picorv32_arb_rr_pick, a combinational picker taking (valid[1:0], last_grant) and returning (grant, grant_id).

## Test plan
- After reset, m0 reads addr 0x8000_0000 with mem_ready one cycle later and rdata 0xF0FF0FAA:
  - mem_valid is high the cycle after the request, mem_addr = 0x8000_0000, mem_wstrb = 0.
  - m0_mem_ready pulses exactly once with m0_mem_rdata = 0xF0FF0FAA; m1_mem_ready stays 0.
- m0 and m1 both valid from reset, both writing (wstrb 1111, data 0x11/0x22):
  - Downstream order is m0 then m1; wdata 0x11 then 0x22.
  - Each requester gets one ready pulse.
  - Total time is 6 cycles with zero-wait mem_ready.
- Both requesters continuously valid for 8 transactions: grant_id sequence is 0,1,0,1,0,1,0,1.
- Downstream holds mem_ready low for 5 cycles: mem_valid, mem_addr, mem_wdata and mem_wstrb are unchanged across all 5 cycles; the ready pulse follows the cycle after mem_ready.
- Reset asserted while in BUSY:
  - Next cycle mem_valid=0, busy=0, state=IDLE, both readies 0.
  - A later m1 request is served normally.
- Spurious mem_ready pulse in IDLE with no requests: no ready output toggles and the state stays IDLE.
